// File: rtl/biriscv_v_issue.sv
// Vector issue/writeback sequencer: owns the 32-entry VRF and issues one instruction at a time.
// Latency: accept at N, request at N+1, earliest idle at N+2. The front end stalls while ISSUE waits.
// Build option: define BIRISCV_VRF_RESET_EN to make rst_i clear the register file.
module biriscv_v_issue #(
    parameter int VLEN    = 128,
    parameter int ELEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inst_valid_i,
    input  logic [31:0]     inst_opcode_i,
    input  logic [31:0]     inst_pc_i,
    input  logic            inst_invalid_i,
    input  logic [31:0]     inst_ra_operand_i,
    input  logic [31:0]     inst_rb_operand_i,
    output logic            inst_accept_o,
    output logic            opcode_valid_o,
    output logic [31:0]     opcode_opcode_o,
    output logic [31:0]     opcode_pc_o,
    output logic            opcode_invalid_o,
    output logic [4:0]      opcode_vd_idx_o,
    output logic [4:0]      opcode_ra_idx_o,
    output logic [4:0]      opcode_rb_idx_o,
    output logic [4:0]      opcode_va_idx_o,
    output logic [4:0]      opcode_vb_idx_o,
    output logic [31:0]     opcode_ra_operand_o,
    output logic [31:0]     opcode_rb_operand_o,
    output logic [VLEN-1:0] opcode_va_operand_o,
    output logic [VLEN-1:0] opcode_vb_operand_o,
    output logic [VLEN-1:0] opcode_vmask_operand_o,
    input  logic            writeback_valid_i,
    input  logic [VLEN-1:0] writeback_value_i,
    input  logic            vrf_wr_i,
    input  logic [4:0]      vrf_wr_idx_i,
    input  logic [VLEN-1:0] vrf_wr_value_i,
    input  logic [4:0]      vrf_rd_idx_i,
    output logic [VLEN-1:0] vrf_rd_value_o,
    output logic            busy_o,
    output logic            timeout_o
);

    if ((VLEN % ELEN) != 0 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("biriscv_v_issue: illegal VLEN/ELEN/TIMEOUT combination");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t          state_q;
    logic [7:0]      count_q;
    logic            valid_q;
    logic [31:0]     opcode_q;
    logic [31:0]     pc_q;
    logic            invalid_q;
    logic [31:0]     ra_q;
    logic [31:0]     rb_q;
    logic [VLEN-1:0] va_q;
    logic [VLEN-1:0] vb_q;
    logic [VLEN-1:0] vm_q;
    logic [VLEN-1:0] vrf_q [32];

    logic            in_idle;
    logic            in_issue;
    logic            accept_fire;
    logic            wb_fire;
    logic            timeout_hit;
    logic            vrf_we;
    logic [4:0]      vrf_widx;
    logic [VLEN-1:0] vrf_wdat;

    assign in_idle     = (state_q == ST_IDLE);
    assign in_issue    = (state_q == ST_ISSUE);
    assign accept_fire = in_idle && inst_valid_i && !rst_i;
    assign wb_fire     = in_issue && writeback_valid_i && !rst_i;
    // Writeback wins over expiry when both land in the final wait cycle.
    assign timeout_hit = in_issue && !writeback_valid_i && !rst_i &&
                         (count_q == 8'(TIMEOUT - 1));

    always_comb begin
        vrf_we   = 1'b0;
        vrf_widx = vrf_wr_idx_i;
        vrf_wdat = vrf_wr_value_i;
        if (!rst_i) begin
            if (in_idle && vrf_wr_i) begin
                vrf_we = 1'b1;
            end else if (wb_fire && !invalid_q) begin
                vrf_we   = 1'b1;
                vrf_widx = opcode_q[11:7];
                vrf_wdat = writeback_value_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            count_q   <= 8'd0;
            valid_q   <= 1'b0;
            opcode_q  <= 32'd0;
            pc_q      <= 32'd0;
            invalid_q <= 1'b0;
            ra_q      <= 32'd0;
            rb_q      <= 32'd0;
            va_q      <= '0;
            vb_q      <= '0;
            vm_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_fire) begin
                        state_q   <= ST_ISSUE;
                        valid_q   <= 1'b1;
                        count_q   <= 8'd0;
                        opcode_q  <= inst_opcode_i;
                        pc_q      <= inst_pc_i;
                        invalid_q <= inst_invalid_i;
                        ra_q      <= inst_ra_operand_i;
                        rb_q      <= inst_rb_operand_i;
                        // Nonblocking reads capture the pre-preload contents.
                        va_q      <= vrf_q[inst_opcode_i[24:20]];
                        vb_q      <= vrf_q[inst_opcode_i[19:15]];
                        vm_q      <= vrf_q[0];
                    end
                end
                ST_ISSUE: begin
                    if (wb_fire || timeout_hit) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end else begin
                        count_q <= count_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BIRISCV_VRF_RESET_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                vrf_q[i] <= '0;
            end
        end else if (vrf_we) begin
            vrf_q[vrf_widx] <= vrf_wdat;
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (vrf_we) begin
            vrf_q[vrf_widx] <= vrf_wdat;
        end
    end
`endif

    assign inst_accept_o          = in_idle;
    assign busy_o                 = in_issue;
    assign timeout_o              = timeout_hit;
    assign opcode_valid_o         = valid_q;
    assign opcode_opcode_o        = opcode_q;
    assign opcode_pc_o            = pc_q;
    assign opcode_invalid_o       = invalid_q;
    assign opcode_vd_idx_o        = opcode_q[11:7];
    assign opcode_ra_idx_o        = opcode_q[19:15];
    assign opcode_rb_idx_o        = opcode_q[24:20];
    assign opcode_va_idx_o        = opcode_q[24:20];
    assign opcode_vb_idx_o        = opcode_q[19:15];
    assign opcode_ra_operand_o    = ra_q;
    assign opcode_rb_operand_o    = rb_q;
    assign opcode_va_operand_o    = va_q;
    assign opcode_vb_operand_o    = vb_q;
    assign opcode_vmask_operand_o = vm_q;
    assign vrf_rd_value_o         = vrf_q[vrf_rd_idx_i];

endmodule
